// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one Wishbone-classic style memory port between instruction fetch (IF)
// and the memory-access stage (MEM) of the pipeline. One bus cycle runs at a
// time. The winner gets its read data and a single-cycle done pulse. A
// watchdog counter aborts bus cycles that never see an acknowledge.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   mem_req_i/we/addr/sel/wdata -> memory-stage request, held until mem_done_o
//   mem_rdata_o, mem_done_o     <- memory-stage load data and completion pulse
//   if_req_i/addr               -> fetch request, held until if_done_o
//   if_rdata_o, if_done_o       <- instruction word and completion pulse
//   flush_i                     -> pipeline flush, discards in-flight fetch data
//   stallreq_mem_o, stallreq_if_o <- combinational stall requests
//   bus_cyc/stb/we/adr/sel/dat_o  <- registered bus master outputs
//   bus_dat_i, bus_ack_i          -> bus slave response
//   bus_err_o                     <- one-cycle pulse when a cycle times out
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_done_o,

    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_done_o,

    input  logic        flush_i,
    output logic        stallreq_mem_o,
    output logic        stallreq_if_o,

    output logic        bus_cyc_o,
    output logic        bus_stb_o,
    output logic        bus_we_o,
    output logic [31:0] bus_adr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_dat_o,
    input  logic [31:0] bus_dat_i,
    input  logic        bus_ack_i,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_BUSY = 2'd1,
        IF_BUSY  = 2'd2
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        last_if_q, last_if_d;   // 1 = fetch won the previous grant
    logic [15:0] cnt_q, cnt_d;
    logic        discard_q, discard_d;   // fetch result to be dropped (flush seen)

    logic        cyc_d, stb_d, we_d, done_mem_d, done_if_d, err_d;
    logic [31:0] adr_d, dat_d, mem_rdata_d, if_rdata_d;
    logic [3:0]  sel_d;
    logic        mem_elig, if_elig;
    logic        drop_if;

    // A requester still seeing its done pulse must not be re-granted,
    // otherwise a held request would issue a second bus cycle.
    assign stallreq_mem_o = mem_req_i & ~mem_done_o;
    assign stallreq_if_o  = if_req_i & ~if_done_o & ~flush_i;

    always_comb begin
        state_d     = state_q;
        last_if_d   = last_if_q;
        cnt_d       = cnt_q;
        discard_d   = discard_q;
        cyc_d       = bus_cyc_o;
        stb_d       = bus_stb_o;
        we_d        = bus_we_o;
        adr_d       = bus_adr_o;
        sel_d       = bus_sel_o;
        dat_d       = bus_dat_o;
        mem_rdata_d = mem_rdata_o;
        if_rdata_d  = if_rdata_o;
        done_mem_d  = 1'b0;
        done_if_d   = 1'b0;
        err_d       = 1'b0;
        mem_elig    = mem_req_i & ~mem_done_o;
        if_elig     = if_req_i & ~if_done_o & ~flush_i;
        drop_if     = discard_q | flush_i;

        case (state_q)
            IDLE: begin
                discard_d = 1'b0;
                // On a tie the requester that did not win last time goes first.
                if (mem_elig && (!if_elig || last_if_q)) begin
                    cyc_d     = 1'b1;
                    stb_d     = 1'b1;
                    we_d      = mem_we_i;
                    adr_d     = mem_addr_i;
                    sel_d     = mem_sel_i;
                    dat_d     = mem_wdata_i;
                    last_if_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = MEM_BUSY;
                end else if (if_elig) begin
                    cyc_d     = 1'b1;
                    stb_d     = 1'b1;
                    we_d      = 1'b0;
                    adr_d     = if_addr_i;
                    sel_d     = 4'hF;
                    dat_d     = '0;
                    last_if_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = IF_BUSY;
                end
            end

            MEM_BUSY, IF_BUSY: begin
                cnt_d = 16'(cnt_q + 16'd1);
                if (state_q == IF_BUSY && flush_i) begin
                    discard_d = 1'b1;
                end
                // Ack has priority over the watchdog in the same cycle.
                if (bus_ack_i || cnt_q == CNT_LAST) begin
                    cyc_d     = 1'b0;
                    stb_d     = 1'b0;
                    we_d      = 1'b0;
                    err_d     = ~bus_ack_i;
                    cnt_d     = '0;
                    discard_d = 1'b0;
                    state_d   = IDLE;
                    if (state_q == MEM_BUSY) begin
                        done_mem_d  = 1'b1;
                        mem_rdata_d = bus_ack_i ? bus_dat_i : 32'd0;
                    end else if (!drop_if) begin
                        done_if_d  = 1'b1;
                        if_rdata_d = bus_ack_i ? bus_dat_i : 32'd0;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_if_q   <= 1'b1;
            cnt_q       <= '0;
            discard_q   <= 1'b0;
            bus_cyc_o   <= 1'b0;
            bus_stb_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_adr_o   <= '0;
            bus_sel_o   <= '0;
            bus_dat_o   <= '0;
            mem_rdata_o <= '0;
            if_rdata_o  <= '0;
            mem_done_o  <= 1'b0;
            if_done_o   <= 1'b0;
            bus_err_o   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_if_q   <= last_if_d;
            cnt_q       <= cnt_d;
            discard_q   <= discard_d;
            bus_cyc_o   <= cyc_d;
            bus_stb_o   <= stb_d;
            bus_we_o    <= we_d;
            bus_adr_o   <= adr_d;
            bus_sel_o   <= sel_d;
            bus_dat_o   <= dat_d;
            mem_rdata_o <= mem_rdata_d;
            if_rdata_o  <= if_rdata_d;
            mem_done_o  <= done_mem_d;
            if_done_o   <= done_if_d;
            bus_err_o   <= err_d;
        end
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single external memory bus port between instruction fetch and the memory-access stage of the five-stage pipeline.
- Arbitrates between the two requesters and runs one Wishbone-style classic bus cycle at a time.
- Returns read data and a one-cycle done pulse to the winning requester.
- Raises per-requester stall requests to the pipeline controller and terminates hung bus cycles with a timeout.

Parameters:
- TIMEOUT, 256, cycles without bus_ack_i before the cycle is aborted; legal range 2..65535.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- mem_req_i  in  1  memory-stage access request; held until mem_done_o
- mem_we_i  in  1  1 = store, 0 = load
- mem_addr_i  in  32  byte address
- mem_sel_i  in  4  byte lane enables
- mem_wdata_i  in  32  store data
- mem_rdata_o  out  32  load data; valid while mem_done_o = 1
- mem_done_o  out  1  one-cycle completion pulse for the memory stage
- if_req_i  in  1  fetch request; held until if_done_o
- if_addr_i  in  32  fetch address
- if_rdata_o  out  32  instruction word; valid while if_done_o = 1
- if_done_o  out  1  one-cycle completion pulse for fetch
- flush_i  in  1  pipeline flush; discards fetch results
- stallreq_mem_o  out  1  memory-stage stall request
- stallreq_if_o  out  1  fetch stall request
- bus_cyc_o  out  1  bus cycle active
- bus_stb_o  out  1  bus strobe
- bus_we_o  out  1  bus write enable
- bus_adr_o  out  32  bus address
- bus_sel_o  out  4  bus byte selects
- bus_dat_o  out  32  bus write data
- bus_dat_i  in  32  bus read data
- bus_ack_i  in  1  bus acknowledge
- bus_err_o  out  1  one-cycle pulse on timeout abort

Behaviour:
- Clock and reset: clk rising edge; rst asynchronous, active-high.
- Reset values: every registered output is 0, state = IDLE, timeout counter = 0, last_grant = IF (so data wins the first tie).
- Registered outputs: all bus_* outputs, *_rdata_o, *_done_o and bus_err_o are registered.
- Stall outputs are combinational:
  - stallreq_mem_o = mem_req_i & ~mem_done_o
  - stallreq_if_o = if_req_i & ~if_done_o & ~flush_i
- States: IDLE, MEM_BUSY, IF_BUSY.
- IDLE:
  - A requester is eligible when its req_i = 1 and its done_o = 0 in this cycle. This prevents re-issue while the requester is still seeing its done pulse.
  - Fetch is also ineligible while flush_i = 1.
  - If only one requester is eligible, grant it.
  - If both are eligible, grant the one that is not last_grant (alternating fairness).
  - On grant: next edge sets bus_cyc_o = bus_stb_o = 1 and latches address, sel, we and wdata into the bus_* registers.
    - Fetch: we = 0, sel = 4'hF, dat_o = 0.
  - Also on grant: update last_grant, clear the counter, and enter MEM_BUSY or IF_BUSY.
- MEM_BUSY / IF_BUSY:
  - Bus registers are held stable and the counter increments each cycle.
  - On bus_ack_i = 1: next edge drops cyc/stb/we; rdata_o <= bus_dat_i (the value is also captured on writes); that requester's done_o = 1 for exactly one cycle; return to IDLE.
  - Minimum latency: request seen in IDLE at cycle t, cyc at t+1, ack at t+1 gives done at t+2.
  - Timeout: if the counter reaches TIMEOUT-1 with no ack, next edge drops cyc/stb, rdata_o <= 0, done_o = 1, bus_err_o = 1 (one cycle each), return to IDLE.
  - Ack in the same cycle as the timeout: ack wins, no error.
- Flush:
  - flush_i during IF_BUSY, or in any cycle of that bus cycle, sets an internal discard flag.
  - The bus cycle completes normally (it is never abandoned), but if_done_o stays 0 and if_rdata_o is not updated. The discard flag clears on return to IDLE.
  - flush_i has no effect on memory-stage transactions.
- Requester inputs are sampled only at grant; later changes during the bus cycle are ignored.
- A requester dropping req_i mid-cycle does not abort the bus cycle; its done pulse is still produced.
- Reset mid-transaction: outputs clear immediately (asynchronous), the bus cycle is abandoned and no done is produced.
- Counter is 16 bits wide and saturates only via the timeout.

Test Plan:
- Single load: mem_req_i = 1, addr 0x0000_0100, bus acks 2 cycles after cyc with dat 0xDEAD_BEEF -> bus_adr_o = 0x100, we = 0, sel = mem_sel_i. mem_done_o pulses once with rdata 0xDEAD_BEEF. stallreq_mem_o = 1 until done. Exactly one bus cycle is issued even though req is still high during the done cycle.
- Store: mem_we_i = 1, sel 4'b0011, wdata 0x1234_5678 -> bus_we_o = 1, bus_dat_o = 0x1234_5678, sel 0011 held until ack; then mem_done_o pulses.
- Contention: both requests held continuously from reset -> grant order MEM, IF, MEM, IF; each done pulses exactly once per bus cycle, with no idle-cycle double grant.
- Flush: flush_i pulsed during an IF_BUSY cycle with ack 3 cycles later -> bus cycle completes, if_done_o stays 0, if_rdata_o unchanged. A pending mem request is granted next.
- Timeout: TIMEOUT = 4, no ack -> cyc drops after 4 cycles; mem_done_o = 1, bus_err_o = 1, mem_rdata_o = 0. Repeat with ack in cycle 4 -> no error, data returned.
- Reset: assert rst during MEM_BUSY -> bus_cyc_o, bus_stb_o and all outputs go to 0 without a clock edge; after release, the first tie is granted to mem.
